// File: rtl/pot_scan_controller_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pot_scan_controller_pkg : scan FSM encoding and default ADC timing
// Rev 1.0
// ----------------------------------------------------------------------------
package pot_scan_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_START    = 3'd2,
    ST_WAIT_EOC = 3'd3,
    ST_READ     = 3'd4,
    ST_NEXT     = 3'd5
  } scan_state_e;

  localparam int DEF_SCAN_DIV       = 100000;
  localparam int DEF_SETTLE_CYCLES  = 16;
  localparam int DEF_START_CYCLES   = 10;
  localparam int DEF_READ_CYCLES    = 4;
  localparam int DEF_TIMEOUT_CYCLES = 20000;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pot_scan_controller_sync_2ff.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_2ff : two-flop synchronizer with asynchronous active-low reset
// Rev 1.0
// ----------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/pot_scan_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pot_scan_controller : sequences a shared ADC0808-class front end over both paddles
// Rev 1.0
// ----------------------------------------------------------------------------
module pot_scan_controller
  import pot_scan_controller_pkg::*;
#(
  parameter int SCAN_DIV       = DEF_SCAN_DIV,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int START_CYCLES   = DEF_START_CYCLES,
  parameter int READ_CYCLES    = DEF_READ_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] adc_data,
  input  logic       adc_eoc,
  output logic       adc_sel,
  output logic       adc_start,
  output logic       adc_oe,
  output logic [7:0] value0,
  output logic [7:0] value1,
  output logic       valid,
  output logic       valid_ch,
  output logic [1:0] timeout_err,
  output logic       busy
);

  localparam int TMR_MAX = max_of(max_of(SETTLE_CYCLES, START_CYCLES),
                                  max_of(READ_CYCLES, TIMEOUT_CYCLES));
  localparam int TW = $clog2(TMR_MAX + 1);
  localparam int CW = $clog2(SCAN_DIV);

  localparam logic [CW-1:0] CNT_LAST     = CW'(SCAN_DIV - 1);
  localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] START_LAST   = TW'(START_CYCLES - 1);
  localparam logic [TW-1:0] READ_LAST    = TW'(READ_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  scan_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          pending_q, pending_d;
  logic          ch_q, ch_d;
  logic          sel_q, sel_d;
  logic          seen_low_q, seen_low_d;
  logic [7:0]    value0_q, value0_d;
  logic [7:0]    value1_q, value1_d;
  logic          valid_q, valid_d;
  logic          valid_ch_q, valid_ch_d;
  logic [1:0]    terr_q, terr_d;
  logic          eoc_s;
  logic          tick_w;

  sync_2ff #(.WIDTH(1)) u_eoc_sync (
    .clk_i  (sys_clk),
    .rst_ni (reset),
    .d_i    (adc_eoc),
    .q_o    (eoc_s)
  );

  assign tick_w = (cnt_q == CNT_LAST);
  assign cnt_d  = tick_w ? '0 : cnt_q + CW'(1);

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tmr_q      <= '0;
      pending_q  <= 1'b0;
      ch_q       <= 1'b0;
      sel_q      <= 1'b0;
      seen_low_q <= 1'b0;
      value0_q   <= '0;
      value1_q   <= '0;
      valid_q    <= 1'b0;
      valid_ch_q <= 1'b0;
      terr_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      pending_q  <= pending_d;
      ch_q       <= ch_d;
      sel_q      <= sel_d;
      seen_low_q <= seen_low_d;
      value0_q   <= value0_d;
      value1_q   <= value1_d;
      valid_q    <= valid_d;
      valid_ch_q <= valid_ch_d;
      terr_q     <= terr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    pending_d  = pending_q;
    ch_d       = ch_q;
    sel_d      = sel_q;
    seen_low_d = seen_low_q;
    value0_d   = value0_q;
    value1_d   = value1_q;
    valid_d    = 1'b0;
    valid_ch_d = valid_ch_q;
    terr_d     = terr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pending_q && enable) begin
          pending_d = 1'b0;
          ch_d      = 1'b0;
          sel_d     = 1'b0;
          tmr_d     = '0;
          state_d   = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (tmr_q == SETTLE_LAST) begin
          tmr_d   = '0;
          state_d = ST_START;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_START: begin
        if (tmr_q == START_LAST) begin
          tmr_d      = '0;
          seen_low_d = 1'b0;
          state_d    = ST_WAIT_EOC;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_WAIT_EOC: begin
        // A high EOC only counts after a low has been seen, so a stale EOC is ignored.
        if (seen_low_q && eoc_s) begin
          tmr_d   = '0;
          state_d = ST_READ;
        end else if (tmr_q == TIMEOUT_LAST) begin
          terr_d[ch_q] = 1'b1;
          state_d      = ST_NEXT;
        end else begin
          tmr_d = tmr_q + TW'(1);
          if (!eoc_s) begin
            seen_low_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (tmr_q == READ_LAST) begin
          if (ch_q) begin
            value1_d = adc_data;
          end else begin
            value0_d = adc_data;
          end
          valid_d      = 1'b1;
          valid_ch_d   = ch_q;
          terr_d[ch_q] = 1'b0;
          tmr_d        = '0;
          state_d      = ST_NEXT;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_NEXT: begin
        if (!ch_q && enable) begin
          ch_d    = 1'b1;
          sel_d   = 1'b1;
          tmr_d   = '0;
          state_d = ST_SELECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Applied last so a tick in the same cycle IDLE consumes the flag is not lost.
    if (tick_w && enable) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    adc_start = 1'b0;
    adc_oe    = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      ST_IDLE:  busy      = 1'b0;
      ST_START: adc_start = 1'b1;
      ST_READ:  adc_oe    = 1'b1;
      default:  ;
    endcase
  end

  assign adc_sel     = sel_q;
  assign value0      = value0_q;
  assign value1      = value1_q;
  assign valid       = valid_q;
  assign valid_ch    = valid_ch_q;
  assign timeout_err = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_pot_scan_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pot_scan_controller : ADC model plus scoreboard bench for pot_scan_controller
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pot_scan_controller;

  localparam int SD  = 200;
  localparam int SD5 = 20;
  localparam int ST  = 2;
  localparam int SC  = 3;
  localparam int RC  = 2;
  localparam int TO  = 50;

  logic       sys_clk = 1'b0;
  logic       reset   = 1'b0;
  logic       enable  = 1'b0;
  logic       enable5 = 1'b0;
  logic [7:0] adc_data;
  logic       adc_eoc;

  logic       sel_a, start_a, oe_a, valid_a, vch_a, busy_a;
  logic [7:0] v0_a, v1_a;
  logic [1:0] te_a;
  logic       sel_b, start_b, oe_b, valid_b, vch_b, busy_b;
  logic [7:0] v0_b, v1_b;
  logic [1:0] te_b;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       ch;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [7:0] mon_v;

  // ADC model: EOC idles high, drops drop_dly cycles after START falls, rises high_dly later
  bit         use5     = 1'b0;
  bit         hang_ch1 = 1'b0;
  int         drop_dly = 2;
  int         high_dly = 10;
  logic [7:0] d0       = 8'hA5;
  logic [7:0] d1       = 8'h3C;
  logic [7:0] result   = 8'h00;
  logic       eoc_r    = 1'b1;
  logic       prev_start = 1'b0;
  logic       conv_ch  = 1'b0;
  bit         armed    = 1'b0;
  int         mcnt     = 0;
  logic       m_sel, m_start, m_oe;

  assign m_sel    = use5 ? sel_b   : sel_a;
  assign m_start  = use5 ? start_b : start_a;
  assign m_oe     = use5 ? oe_b    : oe_a;
  assign adc_eoc  = eoc_r;
  assign adc_data = m_oe ? result : 8'hFF;

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (prev_start && !m_start) begin
      armed   = 1'b1;
      mcnt    = 0;
      conv_ch = m_sel;
    end else if (armed) begin
      mcnt++;
      if (mcnt == drop_dly) eoc_r = 1'b0;
      if (mcnt == drop_dly + high_dly) begin
        armed = 1'b0;
        if (!(hang_ch1 && conv_ch)) begin
          result = conv_ch ? d1 : d0;
          eoc_r  = 1'b1;
        end
      end
    end
    prev_start = m_start;
  end

  pot_scan_controller #(
    .SCAN_DIV(SD), .SETTLE_CYCLES(ST), .START_CYCLES(SC),
    .READ_CYCLES(RC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .enable(enable),
    .adc_data(adc_data), .adc_eoc(adc_eoc),
    .adc_sel(sel_a), .adc_start(start_a), .adc_oe(oe_a),
    .value0(v0_a), .value1(v1_a), .valid(valid_a), .valid_ch(vch_a),
    .timeout_err(te_a), .busy(busy_a)
  );

  pot_scan_controller #(
    .SCAN_DIV(SD5), .SETTLE_CYCLES(ST), .START_CYCLES(SC),
    .READ_CYCLES(RC), .TIMEOUT_CYCLES(TO)
  ) dut5 (
    .sys_clk(sys_clk), .reset(reset), .enable(enable5),
    .adc_data(adc_data), .adc_eoc(adc_eoc),
    .adc_sel(sel_b), .adc_start(start_b), .adc_oe(oe_b),
    .value0(v0_b), .value1(v1_b), .valid(valid_b), .valid_ch(vch_b),
    .timeout_err(te_b), .busy(busy_b)
  );

  always @(negedge sys_clk) begin
    if (reset) begin
      if (start_a || oe_a) begin
        checks++;
        if (start_a && oe_a) begin
          errors++;
          $display("FAIL excl: adc_start=%b adc_oe=%b, required never both 1", start_a, oe_a);
        end
      end
      if (valid_a) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: valid ch=%0d v0=%h v1=%h, required no valid", vch_a, v0_a, v1_a);
        end else begin
          mon_e = sb.pop_front();
          mon_v = vch_a ? v1_a : v0_a;
          if (vch_a !== mon_e.ch || mon_v !== mon_e.val) begin
            errors++;
            $display("FAIL sb_value: got ch=%0d val=%h, required ch=%0d val=%h",
                     vch_a, mon_v, mon_e.ch, mon_e.val);
          end
        end
      end
    end
  end

  task automatic wait_for(input bit which5, input bit level, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if ((which5 ? busy_b : busy_a) == level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_scan_a(output bit ok);
    bit ok1, ok2;
    enable = 1'b1;
    wait_for(1'b0, 1'b1, SD + 60, ok1);
    ok2 = 1'b0;
    if (ok1) wait_for(1'b0, 1'b0, 400, ok2);
    enable = 1'b0;
    ok = ok1 && ok2;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({start_a, oe_a, sel_a, busy_a, valid_a, vch_a} !== 6'b0) begin
      errors++;
      $display("FAIL rst_ctrl: start/oe/sel/busy/valid/vch=%b, required 000000",
               {start_a, oe_a, sel_a, busy_a, valid_a, vch_a});
    end
    checks++;
    if (v0_a !== 8'h00 || v1_a !== 8'h00) begin
      errors++;
      $display("FAIL rst_values: value0=%h value1=%h, required 00 00", v0_a, v1_a);
    end
    checks++;
    if (te_a !== 2'b00) begin
      errors++;
      $display("FAIL rst_terr: timeout_err=%b, required 00", te_a);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic;
    bit ok;
    int st_hi = 0;
    int pulses = 0;
    logic prev = 1'b0;
    sb.push_back(exp_t'{ch: 1'b0, val: 8'hA5});
    sb.push_back(exp_t'{ch: 1'b1, val: 8'h3C});
    enable = 1'b1;
    wait_for(1'b0, 1'b1, SD + 60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_start: busy=%b, required 1 within %0d cycles", busy_a, SD + 60);
    end
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clk);
      if (start_a) st_hi++;
      if (start_a && !prev) pulses++;
      prev = start_a;
      if (!busy_a) begin
        ok = 1'b1;
        break;
      end
    end
    enable = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_done: busy=%b, required 0 within 400 cycles", busy_a);
    end
    checks++;
    if (st_hi != 2 * SC || pulses != 2) begin
      errors++;
      $display("FAIL basic_start_pulse: high=%0d pulses=%0d, required high=%0d pulses=2", st_hi, pulses, 2 * SC);
    end
    checks++;
    if (v0_a !== 8'hA5 || v1_a !== 8'h3C || te_a !== 2'b00) begin
      errors++;
      $display("FAIL basic_values: v0=%h v1=%h terr=%b, required A5 3C 00", v0_a, v1_a, te_a);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL basic_sb: %0d valids missing, required 0", sb.size());
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int pulses = 0;
    int wcnt = 0;
    logic prev = 1'b0;
    hang_ch1 = 1'b1;
    sb.push_back(exp_t'{ch: 1'b0, val: 8'hA5});
    enable = 1'b1;
    wait_for(1'b0, 1'b1, SD + 60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL to_start: busy=%b, required 1", busy_a);
    end
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge sys_clk);
      if (start_a && !prev) pulses++;
      prev = start_a;
      if (pulses == 2 && !start_a && busy_a) wcnt++;
      if (!busy_a) begin
        ok = 1'b1;
        break;
      end
    end
    enable = 1'b0;
    checks++;
    if (!ok || wcnt != TO + 1) begin
      errors++;
      $display("FAIL to_wait_len: done=%0d ch1 wait+next=%0d, required 1 and %0d", ok, wcnt, TO + 1);
    end
    checks++;
    if (te_a !== 2'b10 || v1_a !== 8'h3C) begin
      errors++;
      $display("FAIL to_flag: terr=%b v1=%h, required 10 3C", te_a, v1_a);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL to_sb: %0d valids missing, required 0", sb.size());
    end
    hang_ch1 = 1'b0;
    sb.push_back(exp_t'{ch: 1'b0, val: 8'hA5});
    sb.push_back(exp_t'{ch: 1'b1, val: 8'h3C});
    run_scan_a(ok);
    checks++;
    if (!ok || te_a !== 2'b00) begin
      errors++;
      $display("FAIL to_clear: done=%0d terr=%b, required 1 and 00", ok, te_a);
    end
  endtask

  task automatic test_stale_eoc;
    bit ok;
    bit got = 1'b0;
    int pulses = 0;
    int gap = 0;
    logic prev = 1'b0;
    result   = 8'h5A;
    drop_dly = 6;
    sb.push_back(exp_t'{ch: 1'b0, val: 8'hA5});
    sb.push_back(exp_t'{ch: 1'b1, val: 8'h3C});
    enable = 1'b1;
    wait_for(1'b0, 1'b1, SD + 60, ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clk);
      if (start_a && !prev) pulses++;
      prev = start_a;
      if (oe_a) got = 1'b1;
      if (pulses >= 1 && !got && !start_a) gap++;
      if (!busy_a) begin
        ok = 1'b1;
        break;
      end
    end
    enable = 1'b0;
    checks++;
    if (!ok || gap < drop_dly + high_dly) begin
      errors++;
      $display("FAIL stale_gap: done=%0d start->oe=%0d, required >= %0d", ok, gap, drop_dly + high_dly);
    end
    checks++;
    if (v0_a !== 8'hA5 || v1_a !== 8'h3C) begin
      errors++;
      $display("FAIL stale_values: v0=%h v1=%h, required A5 3C", v0_a, v1_a);
    end
    drop_dly = 2;
  endtask

  task automatic test_enable_drop;
    bit ok;
    bit sel1 = 1'b0;
    bit rose = 1'b0;
    d0 = 8'h77;
    sb.push_back(exp_t'{ch: 1'b0, val: 8'h77});
    enable = 1'b1;
    wait_for(1'b0, 1'b1, SD + 60, ok);
    for (int i = 0; i < 20 && !start_a; i++) @(negedge sys_clk);
    for (int i = 0; i < 20 && start_a; i++) @(negedge sys_clk);
    enable = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clk);
      if (sel_a) sel1 = 1'b1;
      if (!busy_a) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || sel1) begin
      errors++;
      $display("FAIL en_drop_ch1: done=%0d sel1_seen=%0d, required 1 and 0", ok, sel1);
    end
    checks++;
    if (v0_a !== 8'h77 || v1_a !== 8'h3C || sb.size() != 0) begin
      errors++;
      $display("FAIL en_drop_values: v0=%h v1=%h pending=%0d, required 77 3C 0", v0_a, v1_a, sb.size());
    end
    for (int i = 0; i < 2 * SD; i++) begin
      @(negedge sys_clk);
      if (busy_a) rose = 1'b1;
    end
    checks++;
    if (rose) begin
      errors++;
      $display("FAIL en_drop_idle: busy rose=%0d with enable=0, required 0", rose);
    end
    d0 = 8'hA5;
  endtask

  task automatic test_back_to_back;
    bit ok;
    int gap_a = 1;
    int gap_b = 1;
    use5    = 1'b1;
    enable5 = 1'b1;
    wait_for(1'b1, 1'b1, 3 * SD5, ok);
    wait_for(1'b1, 1'b0, 200, ok);
    for (int i = 0; i < 100 && !busy_b; i++) begin
      @(negedge sys_clk);
      if (!busy_b) gap_a++;
    end
    enable5 = 1'b0;
    checks++;
    if (!ok || gap_a != 1) begin
      errors++;
      $display("FAIL b2b_pending: done=%0d idle gap=%0d, required 1 and 1", ok, gap_a);
    end
    wait_for(1'b1, 1'b0, 200, ok);
    enable5 = 1'b1;
    for (int i = 0; i < 100 && !busy_b; i++) begin
      @(negedge sys_clk);
      if (!busy_b) gap_b++;
    end
    checks++;
    if (!ok || gap_b < 2 || gap_b > SD5 + 2) begin
      errors++;
      $display("FAIL b2b_drop: done=%0d idle gap=%0d, required 2..%0d", ok, gap_b, SD5 + 2);
    end
    enable5 = 1'b0;
    wait_for(1'b1, 1'b0, 200, ok);
    use5 = 1'b0;
  endtask

  task automatic test_reset_mid_read;
    bit ok;
    enable = 1'b1;
    wait_for(1'b0, 1'b1, SD + 60, ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (oe_a) begin
        ok = 1'b1;
        break;
      end
    end
    reset  = 1'b0;
    enable = 1'b0;
    #1;
    checks++;
    if (!ok || oe_a !== 1'b0 || start_a !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async: reached_read=%0d oe=%b start=%b, required 1 0 0", ok, oe_a, start_a);
    end
    checks++;
    if (v0_a !== 8'h00 || v1_a !== 8'h00 || te_a !== 2'b00 || busy_a !== 1'b0 || valid_a !== 1'b0) begin
      errors++;
      $display("FAIL rmid_clear: v0=%h v1=%h terr=%b busy=%b valid=%b, required 00 00 00 0 0",
               v0_a, v1_a, te_a, busy_a, valid_a);
    end
    sb.delete();
    repeat (3) @(negedge sys_clk);
    reset = 1'b1;
    sb.push_back(exp_t'{ch: 1'b0, val: 8'hA5});
    sb.push_back(exp_t'{ch: 1'b1, val: 8'h3C});
    run_scan_a(ok);
    checks++;
    if (!ok || v0_a !== 8'hA5 || v1_a !== 8'h3C || sb.size() != 0) begin
      errors++;
      $display("FAIL rmid_resume: done=%0d v0=%h v1=%h missing=%0d, required 1 A5 3C 0",
               ok, v0_a, v1_a, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_stale_eoc();
    test_enable_drop();
    test_back_to_back();
    test_reset_mid_read();
    repeat (2) @(negedge sys_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
